// File: rtl/bp_cce_dir_lru_stream_extract.sv
// Streams directory rows for one set and captures the requesting LCE's LRU way entry.
// Row layout: entry (slot*assoc_p + way) at row_i[idx*entry_w +: entry_w], entry = {tag, state}.
module bp_cce_dir_lru_stream_extract #(
    parameter int tag_sets_per_row_p = 2,
    parameter int assoc_p            = 8,
    parameter int rows_per_set_p     = 4,
    parameter int num_lce_p          = tag_sets_per_row_p * rows_per_set_p,
    parameter int tag_width_p        = 12,
    parameter int row_width_p        = tag_sets_per_row_p * assoc_p * (tag_width_p + 3),
    localparam int lg_num_lce_lp      = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    localparam int lg_assoc_lp        = (assoc_p > 1) ? $clog2(assoc_p) : 1,
    localparam int lg_rows_per_set_lp = (rows_per_set_p > 1) ? $clog2(rows_per_set_p) : 1,
    localparam int coh_bits_lp        = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          req_v_i,
    output logic                          req_ready_o,
    input  logic [lg_num_lce_lp-1:0]      req_lce_i,
    input  logic [lg_assoc_lp-1:0]        req_lru_way_i,
    input  logic                          row_v_i,
    input  logic [row_width_p-1:0]        row_i,
    input  logic [tag_sets_per_row_p-1:0] row_tag_v_i,
    input  logic [lg_rows_per_set_lp-1:0] row_num_i,
    input  logic                          row_last_i,
    output logic                          lru_v_o,
    input  logic                          lru_yumi_i,
    output logic                          lru_found_o,
    output logic                          lru_cached_excl_o,
    output logic [coh_bits_lp-1:0]        lru_state_o,
    output logic [tag_width_p-1:0]        lru_tag_o
);

    localparam int entry_width_lp = tag_width_p + coh_bits_lp;
    localparam int entries_lp     = tag_sets_per_row_p * assoc_p;
    localparam int lg_entries_lp  = (entries_lp > 1) ? $clog2(entries_lp) : 1;
    localparam int lg_tsr_lp      = $clog2(tag_sets_per_row_p);
    localparam int shared_bit_lp  = 0;
    localparam logic [coh_bits_lp-1:0] e_coh_i = 3'b000;

    if ((tag_sets_per_row_p < 1) || ((tag_sets_per_row_p & (tag_sets_per_row_p - 1)) != 0)) begin : g_bad_tsr
        $error("tag_sets_per_row_p must be a power of 2");
    end
    if (num_lce_p != tag_sets_per_row_p * rows_per_set_p) begin : g_bad_lce
        $error("num_lce_p must equal tag_sets_per_row_p * rows_per_set_p");
    end
    if (row_width_p != entries_lp * entry_width_lp) begin : g_bad_row
        $error("row_width_p does not match directory entry packing");
    end

    typedef enum logic [1:0] {
        e_idle,
        e_scan,
        e_done
    } state_e;

    state_e                   fsm_q, fsm_d;
    logic                     ready_q, ready_d;
    logic                     v_q, v_d;
    logic [lg_num_lce_lp-1:0] lce_q, lce_d;
    logic [lg_assoc_lp-1:0]   way_q, way_d;
    logic                     found_q, found_d;
    logic [coh_bits_lp-1:0]   coh_q, coh_d;
    logic [tag_width_p-1:0]   tag_q, tag_d;

    logic [entries_lp-1:0][entry_width_lp-1:0] row_entries;
    logic [lg_num_lce_lp-1:0] tgt_row;
    logic [lg_num_lce_lp-1:0] tgt_slot;
    logic [lg_num_lce_lp-1:0] row_num_ext;
    logic [lg_entries_lp-1:0] entry_sel;
    logic [entry_width_lp-1:0] sel_entry;
    logic                     slot_valid;
    logic                     row_match;

    assign row_entries = row_i;

    // Target decode uses the latched request so the row stream may arrive in any order.
    always_comb begin
        tgt_row     = lce_q >> lg_tsr_lp;
        tgt_slot    = lce_q & lg_num_lce_lp'(tag_sets_per_row_p - 1);
        row_num_ext = lg_num_lce_lp'(row_num_i);
        row_match   = (row_num_ext == tgt_row);
        entry_sel   = lg_entries_lp'(tgt_slot) * lg_entries_lp'(assoc_p) + lg_entries_lp'(way_q);
        sel_entry   = row_entries[entry_sel];
        slot_valid  = |(row_tag_v_i & (tag_sets_per_row_p'(1) << tgt_slot));
    end

    always_comb begin
        fsm_d   = fsm_q;
        ready_d = ready_q;
        v_d     = v_q;
        lce_d   = lce_q;
        way_d   = way_q;
        found_d = found_q;
        coh_d   = coh_q;
        tag_d   = tag_q;
        case (fsm_q)
            e_idle: begin
                if (req_v_i) begin
                    lce_d   = req_lce_i;
                    way_d   = req_lru_way_i;
                    found_d = 1'b0;
                    coh_d   = e_coh_i;
                    tag_d   = '0;
                    ready_d = 1'b0;
                    fsm_d   = e_scan;
                end
            end
            e_scan: begin
                if (row_v_i) begin
                    if (row_match) begin
                        found_d = slot_valid;
                        coh_d   = slot_valid ? sel_entry[coh_bits_lp-1:0] : e_coh_i;
                        tag_d   = slot_valid ? sel_entry[entry_width_lp-1:coh_bits_lp] : '0;
                    end
                    if (row_last_i) begin
                        v_d   = 1'b1;
                        fsm_d = e_done;
                    end
                end
            end
            e_done: begin
                if (lru_yumi_i) begin
                    v_d     = 1'b0;
                    ready_d = 1'b1;
                    fsm_d   = e_idle;
                end
            end
            default: begin
                v_d     = 1'b0;
                ready_d = 1'b1;
                fsm_d   = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fsm_q   <= e_idle;
            ready_q <= 1'b1;
            v_q     <= 1'b0;
            lce_q   <= '0;
            way_q   <= '0;
            found_q <= 1'b0;
            coh_q   <= e_coh_i;
            tag_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            ready_q <= ready_d;
            v_q     <= v_d;
            lce_q   <= lce_d;
            way_q   <= way_d;
            found_q <= found_d;
            coh_q   <= coh_d;
            tag_q   <= tag_d;
        end
    end

    assign req_ready_o       = ready_q;
    assign lru_v_o           = v_q;
    assign lru_found_o       = found_q;
    assign lru_state_o       = coh_q;
    assign lru_tag_o         = tag_q;
    assign lru_cached_excl_o = (|coh_q) & ~coh_q[shared_bit_lp];

endmodule
